// File: rtl/show_rect_ascii_draw_pkg.sv
// Shared constants and types for the ASCII/rectangle drawing engine.
// Opcodes, font geometry, default widths and the engine state encoding.
package show_rect_ascii_draw_pkg;

   localparam int L_W_DEF = 8;
   localparam int C_W_DEF = 3;

   localparam int FONT_W = 8;
   localparam int FONT_H = 16;
   localparam int COL_W  = $clog2(FONT_W);
   localparam int ROW_W  = $clog2(FONT_H);

   localparam logic [1:0] OP_CLEAR = 2'd0;
   localparam logic [1:0] OP_CHAR  = 2'd1;
   localparam logic [1:0] OP_RECT  = 2'd2;

   localparam logic [7:0] ASCII_FIRST = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FETCH,
      ST_CHAR,
      ST_RECT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/show_rect_ascii_draw.sv
// Drawing engine: clears row bands, renders 8x16 glyphs from an external font
// ROM and outlines rectangles, emitting one registered pixel write per cycle.
module show_rect_ascii_draw
   import show_rect_ascii_draw_pkg::*;
#(
   parameter int L_W = L_W_DEF,
   parameter int C_W = C_W_DEF
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic [1:0]         i_cmd_op,
   input  logic [7:0]         i_ascii,
   input  logic [C_W-1:0]     i_color,
   input  logic [L_W-1:0]     i_x,
   input  logic [L_W-1:0]     i_y,
   input  logic [L_W-1:0]     i_x1,
   input  logic [L_W-1:0]     i_y1,
   input  logic [L_W-1:0]     i_x2,
   input  logic [L_W-1:0]     i_y2,
   input  logic [L_W-1:0]     i_ys,
   input  logic [L_W-1:0]     i_ye,
   output logic [10:0]        o_font_addr,
   input  logic [7:0]         i_font_data,
   output logic               o_wr_en,
   output logic [2*L_W-1:0]   o_wr_addr,
   output logic [C_W-1:0]     o_wr_data,
   output logic               o_done
);

   state_t state, state_nxt;

   logic [6:0]       ascii_q;
   logic [C_W-1:0]   color_q;
   logic [L_W-1:0]   x_q, y_q, x1_q, y1_q, x2_q, y2_q, ye_q;
   logic [L_W-1:0]   cnt_x, cnt_y, rect_cnt;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic [1:0]       side;

   logic             wr_en_q;
   logic [2*L_W-1:0] wr_addr_q;
   logic [C_W-1:0]   wr_data_q;

   logic             accept, ascii_ok, clear_last, col_last, row_last, side_end;
   logic             pix_on, clip;
   logic [L_W:0]     x_sum, y_sum;
   logic [2*L_W-1:0] rect_addr;

   assign accept     = (state == ST_IDLE) && i_cmd_valid;
   assign ascii_ok   = (i_ascii >= ASCII_FIRST) && !i_ascii[7];
   assign clear_last = (cnt_x == '1) && (cnt_y == ye_q);
   assign col_last   = (col == COL_W'(FONT_W - 1));
   assign row_last   = (row == ROW_W'(FONT_H - 1));
   assign side_end   = (rect_cnt == (side[1] ? y2_q : x2_q));

   // The extra carry bit flags glyph pixels that fall off the canvas edge.
   assign x_sum  = {1'b0, x_q} + (L_W+1)'(col);
   assign y_sum  = {1'b0, y_q} + (L_W+1)'(row);
   assign clip   = x_sum[L_W] | y_sum[L_W];
   assign pix_on = i_font_data[COL_W'(FONT_W - 1) - col];

   always_comb begin
      rect_addr = {rect_cnt, x2_q};
      unique case (side)
         2'd0:    rect_addr = {y1_q, rect_cnt};
         2'd1:    rect_addr = {y2_q, rect_cnt};
         2'd2:    rect_addr = {rect_cnt, x1_q};
         default: rect_addr = {rect_cnt, x2_q};
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:
            if (i_cmd_valid) begin
               unique case (i_cmd_op)
                  OP_CLEAR: state_nxt = (i_ys > i_ye) ? ST_DONE : ST_CLEAR;
                  OP_CHAR:  state_nxt = ascii_ok ? ST_FETCH : ST_DONE;
                  OP_RECT:  state_nxt = ((i_x1 > i_x2) || (i_y1 > i_y2)) ? ST_DONE : ST_RECT;
                  default:  state_nxt = ST_DONE;
               endcase
            end
         ST_CLEAR: if (clear_last) state_nxt = ST_DONE;
         ST_FETCH: state_nxt = ST_CHAR;
         ST_CHAR:  if (col_last) state_nxt = row_last ? ST_DONE : ST_FETCH;
         ST_RECT:  if ((side == 2'd3) && side_end) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_cmd_ready = 1'b0;
      o_done      = 1'b0;
      unique case (state)
         ST_IDLE: o_cmd_ready = 1'b1;
         ST_DONE: o_done      = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ascii_q  <= '0;
         color_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
         x1_q     <= '0;
         y1_q     <= '0;
         x2_q     <= '0;
         y2_q     <= '0;
         ye_q     <= '0;
         cnt_x    <= '0;
         cnt_y    <= '0;
         rect_cnt <= '0;
         row      <= '0;
         col      <= '0;
         side     <= '0;
      end else if (accept) begin
         ascii_q  <= i_ascii[6:0];
         color_q  <= i_color;
         x_q      <= i_x;
         y_q      <= i_y;
         x1_q     <= i_x1;
         y1_q     <= i_y1;
         x2_q     <= i_x2;
         y2_q     <= i_y2;
         ye_q     <= i_ye;
         cnt_x    <= '0;
         cnt_y    <= i_ys;
         rect_cnt <= i_x1;
         row      <= '0;
         col      <= '0;
         side     <= '0;
      end else begin
         unique case (state)
            ST_CLEAR: begin
               cnt_x <= cnt_x + L_W'(1);
               if (cnt_x == '1) cnt_y <= cnt_y + L_W'(1);
            end
            ST_CHAR: begin
               col <= col + COL_W'(1);
               if (col_last) row <= row + ROW_W'(1);
            end
            // Top/bottom restart at x1, left/right restart at y1.
            ST_RECT: begin
               if (side_end) begin
                  side     <= side + 2'd1;
                  rect_cnt <= (side == 2'd0) ? x1_q : y1_q;
               end else begin
                  rect_cnt <= rect_cnt + L_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         unique case (state)
            ST_CLEAR: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= {cnt_y, cnt_x};
               wr_data_q <= '0;
            end
            ST_CHAR: begin
               wr_en_q   <= pix_on && !clip;
               wr_addr_q <= {y_sum[L_W-1:0], x_sum[L_W-1:0]};
               wr_data_q <= color_q;
            end
            ST_RECT: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= rect_addr;
               wr_data_q <= color_q;
            end
            default: ;
         endcase
      end
   end

   assign o_font_addr = {ascii_q, row};
   assign o_wr_en     = wr_en_q;
   assign o_wr_addr   = wr_addr_q;
   assign o_wr_data   = wr_data_q;

endmodule

// File: tb/tb_show_rect_ascii_draw.sv
// Directed bench for show_rect_ascii_draw with a synchronous font ROM model
// and a write/done monitor feeding hand-built expected write lists.
module tb_show_rect_ascii_draw;

   localparam int L_W = 8;
   localparam int C_W = 3;

   typedef logic [2*L_W+C_W-1:0] wr_t;

   logic             sys_clk = 1'b0;
   logic             sys_rst = 1'b1;
   logic             i_cmd_valid = 1'b0;
   logic             o_cmd_ready;
   logic [1:0]       i_cmd_op = '0;
   logic [7:0]       i_ascii = '0;
   logic [C_W-1:0]   i_color = '0;
   logic [L_W-1:0]   i_x = '0, i_y = '0, i_x1 = '0, i_y1 = '0;
   logic [L_W-1:0]   i_x2 = '0, i_y2 = '0, i_ys = '0, i_ye = '0;
   logic [10:0]      o_font_addr;
   logic [7:0]       i_font_data;
   logic             o_wr_en;
   logic [2*L_W-1:0] o_wr_addr;
   logic [C_W-1:0]   o_wr_data;
   logic             o_done;

   int  checks = 0;
   int  errors = 0;
   int  done_cnt = 0;
   int  acc_cnt = 0;
   wr_t wr_q[$];
   wr_t exp_q[$];

   show_rect_ascii_draw #(.L_W(L_W), .C_W(C_W)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_op    (i_cmd_op),
      .i_ascii     (i_ascii),
      .i_color     (i_color),
      .i_x         (i_x),
      .i_y         (i_y),
      .i_x1        (i_x1),
      .i_y1        (i_y1),
      .i_x2        (i_x2),
      .i_y2        (i_y2),
      .i_ys        (i_ys),
      .i_ye        (i_ye),
      .o_font_addr (o_font_addr),
      .i_font_data (i_font_data),
      .o_wr_en     (o_wr_en),
      .o_wr_addr   (o_wr_addr),
      .o_wr_data   (o_wr_data),
      .o_done      (o_done)
   );

   always #5 sys_clk = ~sys_clk;

   // 'A' has a small hand-drawn glyph, '#' is a solid block, all else blank.
   function automatic logic [7:0] font_row(input logic [10:0] a);
      if (a[10:4] == 7'h41) begin
         case (a[3:0])
            4'd2:    return 8'h18;
            4'd3:    return 8'h3C;
            4'd4:    return 8'h66;
            4'd5:    return 8'h66;
            4'd6:    return 8'h7E;
            4'd7:    return 8'h66;
            4'd8:    return 8'h66;
            4'd9:    return 8'h66;
            default: return 8'h00;
         endcase
      end
      if (a[10:4] == 7'h23) return 8'hFF;
      return 8'h00;
   endfunction

   always @(posedge sys_clk) i_font_data <= font_row(o_font_addr);

   always @(negedge sys_clk) begin
      if (o_wr_en === 1'b1) wr_q.push_back({o_wr_addr, o_wr_data});
      if (o_done === 1'b1) done_cnt++;
      if (i_cmd_valid === 1'b1 && o_cmd_ready === 1'b1) acc_cnt++;
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int x, input int y, input logic [C_W-1:0] c);
      logic [L_W-1:0] xa, ya;
      xa = L_W'(x);
      ya = L_W'(y);
      exp_q.push_back({ya, xa, c});
   endtask

   task automatic compare_writes(input string tag);
      int mism;
      int n;
      mism = 0;
      n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (wr_q[i] !== exp_q[i]) mism++;
      check_output({tag, "_count"}, wr_q.size(), exp_q.size());
      check_output({tag, "_mismatches"}, mism, 0);
   endtask

   task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] ascii,
                                 input logic [C_W-1:0] color,
                                 input int a, input int b, input int c, input int d);
      int w;
      w = 0;
      while (o_cmd_ready !== 1'b1 && w < 8) begin
         tick();
         w++;
      end
      i_cmd_op = op;
      i_ascii  = ascii;
      i_color  = color;
      i_x  = L_W'(a);  i_y  = L_W'(b);
      i_x1 = L_W'(a);  i_y1 = L_W'(b);
      i_x2 = L_W'(c);  i_y2 = L_W'(d);
      i_ys = L_W'(a);  i_ye = L_W'(b);
      i_cmd_valid = 1'b1;
      tick();
      i_cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] ascii,
                          input logic [C_W-1:0] color,
                          input int a, input int b, input int c, input int d,
                          input int budget, input int exp_lat);
      int lat;
      int d0;
      wr_q.delete();
      d0 = done_cnt;
      apply_stimulus(op, ascii, color, a, b, c, d);
      lat = 0;
      while (o_done !== 1'b1 && lat < budget) begin
         tick();
         lat++;
      end
      check_output({tag, "_latency"}, lat, exp_lat);
      tick();
      check_output({tag, "_done_once"}, done_cnt - d0, 1);
      check_output({tag, "_ready_after"}, o_cmd_ready, 1'b1);
      compare_writes(tag);
   endtask

   initial begin
      int n0, d0, a0, n, dn;

      // Reset state
      repeat (3) tick();
      check_output("rst_ready",     o_cmd_ready, 1'b1);
      check_output("rst_wr_en",     o_wr_en,     1'b0);
      check_output("rst_wr_addr",   o_wr_addr,   '0);
      check_output("rst_wr_data",   o_wr_data,   '0);
      check_output("rst_done",      o_done,      1'b0);
      check_output("rst_font_addr", o_font_addr, '0);
      sys_rst = 1'b0;
      tick();

      $display("[TB] clear band 128..191");
      exp_q.delete();
      for (int y = 128; y <= 191; y++)
         for (int x = 0; x < 256; x++) push_exp(x, y, 3'd0);
      run_cmd("clear_band", 2'd0, 8'h00, 3'd7, 128, 191, 0, 0, 20000, 16384);
      check_output("clear_first", wr_q.size() > 0 ? wr_q[0] : '0, {8'd128, 8'd0, 3'd0});
      check_output("clear_last", wr_q.size() > 0 ? wr_q[wr_q.size()-1] : '0, {8'd191, 8'd255, 3'd0});

      exp_q.delete();
      run_cmd("clear_empty", 2'd0, 8'h00, 3'd1, 5, 4, 0, 0, 50, 0);

      $display("[TB] glyph A at (10,20)");
      exp_q.delete();
      for (int r = 0; r < 16; r++) begin
         logic [7:0] bits;
         bits = font_row({7'h41, 4'(r)});
         for (int c = 0; c < 8; c++)
            if (bits[7-c]) push_exp(10 + c, 20 + r, 3'b100);
      end
      check_output("char_a_model_bits", exp_q.size(), 32);
      run_cmd("char_a", 2'd1, 8'h41, 3'b100, 10, 20, 0, 0, 300, 144);

      exp_q.delete();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 4; c++) push_exp(252 + c, 250 + r, 3'b011);
      run_cmd("char_clip", 2'd1, 8'h23, 3'b011, 252, 250, 0, 0, 300, 144);

      exp_q.delete();
      run_cmd("char_ctrl", 2'd1, 8'h10, 3'b001, 0, 0, 0, 0, 50, 0);
      run_cmd("char_high", 2'd1, 8'hC1, 3'b001, 0, 0, 0, 0, 50, 0);
      run_cmd("op_rsvd",   2'd3, 8'h41, 3'b001, 0, 0, 0, 0, 50, 0);

      $display("[TB] rectangle outlines");
      exp_q.delete();
      for (int x = 5; x <= 8; x++) push_exp(x, 6, 3'b010);
      for (int x = 5; x <= 8; x++) push_exp(x, 9, 3'b010);
      for (int y = 6; y <= 9; y++) push_exp(5, y, 3'b010);
      for (int y = 6; y <= 9; y++) push_exp(8, y, 3'b010);
      run_cmd("rect", 2'd2, 8'h00, 3'b010, 5, 6, 8, 9, 100, 16);

      begin
         wr_t keep[$];
         keep = exp_q;
         exp_q.delete();
         run_cmd("rect_bad_x", 2'd2, 8'h00, 3'b010, 9, 6, 8, 9, 50, 0);
         run_cmd("rect_bad_y", 2'd2, 8'h00, 3'b010, 5, 10, 8, 9, 50, 0);
         exp_q = keep;
      end

      // Reset while a large rectangle is mid-way through its top edge
      wr_q.delete();
      d0 = done_cnt;
      apply_stimulus(2'd2, 8'h00, 3'b110, 0, 0, 20, 20);
      repeat (10) tick();
      sys_rst = 1'b1;
      tick();
      check_output("abort_wr_en", o_wr_en, 1'b0);
      check_output("abort_ready", o_cmd_ready, 1'b1);
      check_output("abort_done",  o_done, 1'b0);
      n0 = wr_q.size();
      check_output("abort_pre_writes", n0, 10);
      sys_rst = 1'b0;
      repeat (5) tick();
      check_output("abort_no_writes", wr_q.size(), n0);
      check_output("abort_no_done", done_cnt - d0, 0);
      run_cmd("rect_after_abort", 2'd2, 8'h00, 3'b010, 5, 6, 8, 9, 100, 16);

      $display("[TB] valid held high for three commands");
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         push_exp(1, 1, 3'd5); push_exp(2, 1, 3'd5);
         push_exp(1, 2, 3'd5); push_exp(2, 2, 3'd5);
         push_exp(1, 1, 3'd5); push_exp(1, 2, 3'd5);
         push_exp(2, 1, 3'd5); push_exp(2, 2, 3'd5);
      end
      wr_q.delete();
      d0 = done_cnt;
      a0 = acc_cnt;
      i_cmd_op = 2'd2;
      i_color  = 3'd5;
      i_x1 = 8'd1; i_y1 = 8'd1; i_x2 = 8'd2; i_y2 = 8'd2;
      i_cmd_valid = 1'b1;
      n  = 0;
      dn = 0;
      while (dn < 3 && n < 100) begin
         tick();
         n++;
         if (o_done === 1'b1) dn++;
      end
      i_cmd_valid = 1'b0;
      check_output("b2b_cycles", n, 29);
      repeat (2) tick();
      check_output("b2b_accepts", acc_cnt - a0, 3);
      check_output("b2b_dones", done_cnt - d0, 3);
      check_output("b2b_ready", o_cmd_ready, 1'b1);
      compare_writes("b2b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/show_rect_ascii_draw.md
SHOW_RECT_ASCII_DRAW -- requirements
Module: show_rect_ascii_draw

Interface
REQ-001 L_W, default 8: canvas coordinate width; canvas is 2^L_W x 2^L_W pixels.
REQ-002 C_W, default 3: pixel colour width.
REQ-003 sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 i_cmd_valid  in  1  command offered.
REQ-006 o_cmd_ready  out  1  engine idle, can accept a command.
REQ-007 i_cmd_op  in  2  opcode: 0 CLEAR, 1 CHAR, 2 RECT, 3 reserved.
REQ-008 i_ascii  in  8  character code (CHAR).
REQ-009 i_color  in  C_W  draw colour (CHAR, RECT).
REQ-010 i_x, i_y  in  L_W each  glyph top-left corner (CHAR).
REQ-011 i_x1, i_y1, i_x2, i_y2  in  L_W each  rectangle corners, inclusive (RECT).
REQ-012 i_ys, i_ye  in  L_W each  first and last row to clear, inclusive (CLEAR).
REQ-013 o_font_addr  out  11  font ROM address {ascii[6:0], row[3:0]}.
REQ-014 i_font_data  in  8  glyph row; bit 7 = leftmost pixel; valid 1 cycle after o_font_addr.
REQ-015 o_wr_en  out  1  pixel RAM write strobe.
REQ-016 o_wr_addr  out  2*L_W  pixel address {y, x}.
REQ-017 o_wr_data  out  C_W  pixel colour.
REQ-018 o_done  out  1  one-cycle pulse when a command finishes.

Function
REQ-019 Handshake: a command is accepted on a cycle with i_cmd_valid=1 and o_cmd_ready=1; all command fields are latched that cycle; o_cmd_ready is 1 only in IDLE.
REQ-020 States: IDLE, CLEAR, FETCH, CHAR, RECT, DONE; DONE lasts one cycle, asserts o_done, then returns to IDLE.
REQ-021 Op 3 and CHAR with i_ascii < 0x20 or >= 0x80 go IDLE->DONE with no writes.
REQ-022 CLEAR: one write per cycle of colour 0, x 0..255 inner loop, y i_ys..i_ye outer loop; (ye-ys+1)*256 writes back to back.
REQ-023 CLEAR with i_ys > i_ye: no writes, goes to DONE.
REQ-024 CHAR: 16 rows; per row, FETCH (1 cycle, drive o_font_addr), then CHAR (8 cycles, col 0..7); exactly 144 cycles from accept to DONE.
REQ-025 CHAR pixel (col,row): o_wr_en=1 only if i_font_data[7-col]=1 (transparent background); address {y+row, x+col}; data i_color.
REQ-026 CHAR clipping: suppress the write if x+col or y+row exceeds 2^L_W-1; no wrap-around.
REQ-027 RECT: four edges in order: top (x1..x2 at y1), bottom (x1..x2 at y2), left (y1..y2 at x1), right (y1..y2 at x2); one write per cycle; 2*(x2-x1+1)+2*(y2-y1+1) writes; corners written twice.
REQ-028 RECT with x1 > x2 or y1 > y2: no writes, goes to DONE.
REQ-029 Write-port outputs are registered: the write for a given pixel appears the cycle after its loop counters select it.
REQ-030 i_cmd_valid while busy is ignored; no queueing.

Reset
REQ-031 On sys_rst=1 at a clock edge: state IDLE; o_cmd_ready=1; o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_done=0, o_font_addr=0; all counters and latched fields are 0.
REQ-032 Reset mid-command aborts it: no further writes, no o_done.

Structure
REQ-033 A shared package holds the opcode constants, the font dimensions (8x16), L_W and C_W defaults.
REQ-034 The font ROM is external; no sub-module is required, and the edge walker stays inline in the FSM.

Verification
REQ-035 CLEAR ys=128, ye=191 -> 16384 writes, data 0, first addr {128,0}, last {191,255}, then one o_done.
REQ-036 CHAR 'A' (0x41) at x=10, y=20, colour 3'b100, ROM model -> writes only on set font bits, addresses {20+row, 10+col}, o_done at cycle 144 after accept.
REQ-037 CHAR at x=252, y=250 -> no writes with x>255 or y>255.
REQ-038 RECT (5,6)-(8,9), colour 3'b010 -> 16 writes in top/bottom/left/right order; RECT x1=9, x2=8 -> zero writes, o_done.
REQ-039 sys_rst asserted mid-RECT -> o_wr_en=0 next cycle, no o_done, o_cmd_ready=1; the next command runs correctly.
REQ-040 i_cmd_valid held high continuously -> back-to-back commands accepted only in IDLE, with exactly one o_done per command.
